distribute_tree_credit_scheduler: RTL and testbench

//  Shares the root of a binary distribute tree (a cascade of 1x2 cmd-flow switches) between NUM_REQ requesters.

---
 rtl/distribute_tree_credit_scheduler.sv | 157 +++++++++++++++
 tb/tb_distribute_tree_credit_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distribute_tree_credit_scheduler.sv
// Round-robin, credit-gated scheduler that feeds the root of a binary
// distribute tree built from 1x2 cmd-flow switches.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   i_en              scheduler enable (0 = no grants)
//   i_req_valid/data/dest   per-requester flit, payload and leaf index
//   o_req_ready       one-hot grant (combinational)
//   i_credit_return   per-leaf buffer slot freed
//   o_valid/o_data_bus/o_cmd/o_en   registered drive of the root switch
//   o_grant_id        requester that sourced the current o_valid flit
//   o_credit_err      sticky: credit returned to an already-full counter
module distribute_tree_credit_scheduler #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NUM_LEAF     = 8,
  parameter int unsigned DEST_WIDTH   = 3,
  parameter int unsigned CREDIT_MAX   = 4,
  parameter int unsigned CREDIT_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic [NUM_REQ*DEST_WIDTH-1:0]    i_req_dest,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_LEAF-1:0]              i_credit_return,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data_bus,
  output logic [DEST_WIDTH-1:0]            o_cmd,
  output logic                             o_en,
  output logic [$clog2(NUM_REQ)-1:0]       o_grant_id,
  output logic                             o_credit_err
);

  localparam int unsigned GNT_WIDTH = $clog2(NUM_REQ);

  // State
  logic [CREDIT_WIDTH-1:0] credit_q [NUM_LEAF];
  logic [CREDIT_WIDTH-1:0] credit_d [NUM_LEAF];
  logic [GNT_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DEST_WIDTH-1:0]   cmd_q, cmd_d;
  logic                    en_q, en_d;
  logic [GNT_WIDTH-1:0]    grant_id_q, grant_id_d;
  logic                    err_q, err_d;

  // Arbitration signals
  logic [DEST_WIDTH-1:0]   req_dest_c [NUM_REQ];
  logic [NUM_REQ-1:0]      elig_c;
  logic [GNT_WIDTH-1:0]    cand_c;
  logic [GNT_WIDTH-1:0]    winner_c;
  logic                    win_found_c;
  logic [DATA_WIDTH-1:0]   win_data_c;
  logic [DEST_WIDTH-1:0]   win_dest_c;
  logic [NUM_REQ-1:0]      req_ready_c;

  // Eligibility: only registered credit is consulted, so a credit return
  // never reaches o_req_ready in the same cycle.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_dest_c[r] = i_req_dest[r*DEST_WIDTH +: DEST_WIDTH];
      elig_c[r]     = i_en & i_req_valid[r] & (credit_q[req_dest_c[r]] != '0) & ~rst;
    end
  end

  // Round-robin scan starting at rr_ptr_q
  always_comb begin
    win_found_c = 1'b0;
    winner_c    = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = GNT_WIDTH'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found_c && elig_c[cand_c]) begin
        win_found_c = 1'b1;
        winner_c    = cand_c;
      end
    end
  end

  // Winner payload mux and one-hot ready
  always_comb begin
    win_data_c  = '0;
    win_dest_c  = '0;
    req_ready_c = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (win_found_c && (winner_c == GNT_WIDTH'(r))) begin
        win_data_c     = i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
        win_dest_c     = req_dest_c[r];
        req_ready_c[r] = 1'b1;
      end
    end
  end

  assign o_req_ready = req_ready_c;

  // Next state: issue registers, pointer and credit bookkeeping
  always_comb begin
    valid_d    = win_found_c;
    data_d     = win_found_c ? win_data_c : '0;
    cmd_d      = win_found_c ? win_dest_c : '0;
    grant_id_d = win_found_c ? winner_c : grant_id_q;
    en_d       = i_en;
    rr_ptr_d   = win_found_c ? GNT_WIDTH'((32'(winner_c) + 32'd1) % NUM_REQ) : rr_ptr_q;
    err_d      = err_q;
    for (int unsigned l = 0; l < NUM_LEAF; l++) begin
      credit_d[l] = credit_q[l];
      // Issue and return on the same leaf cancel out. Issue never
      // underflows because a zero-credit leaf is never eligible.
      if (win_found_c && (win_dest_c == DEST_WIDTH'(l))) begin
        if (!i_credit_return[l]) begin
          credit_d[l] = credit_q[l] - CREDIT_WIDTH'(1);
        end
      end else if (i_credit_return[l]) begin
        if (credit_q[l] == CREDIT_WIDTH'(CREDIT_MAX)) begin
          err_d = 1'b1;
        end else begin
          credit_d[l] = credit_q[l] + CREDIT_WIDTH'(1);
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned l = 0; l < NUM_LEAF; l++) begin
        credit_q[l] <= CREDIT_WIDTH'(CREDIT_MAX);
      end
      rr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      cmd_q      <= '0;
      en_q       <= 1'b0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
      en_q       <= en_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data_bus   = data_q;
  assign o_cmd        = cmd_q;
  assign o_en         = en_q;
  assign o_grant_id   = grant_id_q;
  assign o_credit_err = err_q;

endmodule

// File: tb/tb_distribute_tree_credit_scheduler.sv
// Self-checking bench for distribute_tree_credit_scheduler: a per-cycle
// behavioural model plus directed scenarios with literal expectations.
module tb_distribute_tree_credit_scheduler;

  localparam int DW   = 32;
  localparam int NR   = 4;
  localparam int NL   = 8;
  localparam int DSTW = 3;
  localparam int CMAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_en;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR*DSTW-1:0] req_dest;
  logic [NR-1:0]   req_ready;
  logic [NL-1:0]   credit_return;
  logic            o_valid;
  logic [DW-1:0]   o_data_bus;
  logic [DSTW-1:0] o_cmd;
  logic            o_en;
  logic [1:0]      o_grant_id;
  logic            o_credit_err;

  int checks   = 0;
  int failures = 0;

  distribute_tree_credit_scheduler #(
    .DATA_WIDTH(32), .NUM_REQ(4), .NUM_LEAF(8), .DEST_WIDTH(3),
    .CREDIT_MAX(4), .CREDIT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_dest(req_dest),
    .o_req_ready(req_ready), .i_credit_return(credit_return),
    .o_valid(o_valid), .o_data_bus(o_data_bus), .o_cmd(o_cmd), .o_en(o_en),
    .o_grant_id(o_grant_id), .o_credit_err(o_credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_credit [NL];
  int          m_rr;
  bit          model_live = 1'b0;
  logic        exp_valid, exp_en, exp_err;
  logic [DW-1:0] exp_data;
  logic [DSTW-1:0] exp_cmd;
  logic [1:0]  exp_gid;

  function automatic int dest_of(input int r);
    return int'(req_dest[r*DSTW +: DSTW]);
  endfunction

  function automatic int model_winner();
    int r;
    if (rst || !i_en) return -1;
    for (int i = 0; i < NR; i++) begin
      r = (m_rr + i) % NR;
      if (req_valid[r] && m_credit[dest_of(r)] > 0) return r;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    int d;
    int iss;
    if (rst) begin
      for (int l = 0; l < NL; l++) m_credit[l] = CMAX;
      m_rr = 0; exp_valid = 1'b0; exp_data = '0; exp_cmd = '0;
      exp_en = 1'b0; exp_gid = '0; exp_err = 1'b0; model_live = 1'b1;
    end else begin
      w = model_winner();
      d = -1;
      exp_en = i_en;
      if (w >= 0) begin
        d = dest_of(w);
        exp_valid = 1'b1;
        exp_data  = req_data[w*DW +: DW];
        exp_cmd   = DSTW'(d);
        exp_gid   = 2'(w);
        m_rr      = (w + 1) % NR;
      end else begin
        exp_valid = 1'b0; exp_data = '0; exp_cmd = '0;
      end
      for (int l = 0; l < NL; l++) begin
        iss = (l == d) ? 1 : 0;
        if (credit_return[l] && iss == 0 && m_credit[l] == CMAX) exp_err = 1'b1;
        else m_credit[l] = m_credit[l] - iss + int'(credit_return[l]);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    int w;
    logic [NR-1:0] er;
    @(negedge clk);
    if (model_live) begin
      w  = model_winner();
      er = (w >= 0) ? NR'(1 << w) : '0;
      chk("m_ready", 64'(req_ready), 64'(er));
      chk("m_valid", 64'(o_valid), 64'(exp_valid));
      chk("m_data", 64'(o_data_bus), 64'(exp_data));
      chk("m_cmd", 64'(o_cmd), 64'(exp_cmd));
      chk("m_en", 64'(o_en), 64'(exp_en));
      chk("m_gid", 64'(o_grant_id), 64'(exp_gid));
      chk("m_err", 64'(o_credit_err), 64'(exp_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input int d, input logic [DW-1:0] data);
    req_valid[r] = v;
    req_dest[r*DSTW +: DSTW] = DSTW'(d);
    req_data[r*DW +: DW] = data;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; i_en = 1'b1; req_valid = '0; req_data = '0; req_dest = '0;
    credit_return = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_en = 1'b1; req_valid = '0; req_data = '0; req_dest = '0;
    credit_return = '0;

    // 1: all four requesters to leaf 5
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 5, 32'hA000_0000 + 32'(r));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_ready", 64'(req_ready), 64'(1 << k));
      if (k > 0) begin
        chk("t1_gid", 64'(o_grant_id), 64'(k - 1));
        chk("t1_cmd", 64'(o_cmd), 64'd5);
      end
    end
    @(negedge clk);
    chk("t1_ready_empty", 64'(req_ready), 64'd0);
    chk("t1_gid3", 64'(o_grant_id), 64'd3);
    chk("t1_data3", 64'(o_data_bus), 64'hA000_0003);
    chk("t1_model_credit5", 64'(m_credit[5]), 64'd0);

    // 2: leaf 2 exhausted does not block r1 on leaf 6
    do_reset();
    set_req(0, 1'b1, 2, 32'h0000_0200);
    repeat (4) step();
    set_req(1, 1'b1, 6, 32'h0000_0601);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_r1_ready", 64'(req_ready), 64'b0010);
      step();
    end
    @(negedge clk);
    chk("t2_none", 64'(req_ready), 64'd0);
    step();
    credit_return[2] = 1'b1;
    @(negedge clk);
    chk("t2_ret_same_cycle", 64'(req_ready), 64'd0);
    step();
    credit_return[2] = 1'b0;
    @(negedge clk);
    chk("t2_r0_after_ret", 64'(req_ready), 64'b0001);
    chk("t2_model_credit2", 64'(m_credit[2]), 64'd1);

    // 3: issue and return on leaf 3 in the same cycle
    do_reset();
    set_req(0, 1'b1, 3, 32'h0000_0300);
    repeat (3) step();
    credit_return[3] = 1'b1;
    @(negedge clk);
    chk("t3_ready_c1", 64'(req_ready), 64'b0001);
    step();
    credit_return[3] = 1'b0;
    @(negedge clk);
    chk("t3_ready_still1", 64'(req_ready), 64'b0001);
    chk("t3_err", 64'(o_credit_err), 64'd0);
    chk("t3_model_credit3", 64'(m_credit[3]), 64'd1);
    step();
    @(negedge clk);
    chk("t3_ready_empty", 64'(req_ready), 64'd0);

    // 4: return to a full counter
    do_reset();
    credit_return[0] = 1'b1;
    step();
    credit_return[0] = 1'b0;
    @(negedge clk);
    chk("t4_err_set", 64'(o_credit_err), 64'd1);
    chk("t4_model_credit0", 64'(m_credit[0]), 64'd4);
    step();
    step();
    @(negedge clk);
    chk("t4_err_sticky", 64'(o_credit_err), 64'd1);
    step();
    set_req(0, 1'b1, 0, 32'h0000_0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_ready", 64'(req_ready), 64'b0001);
      step();
    end
    @(negedge clk);
    chk("t4_sat_four_only", 64'(req_ready), 64'd0);

    // 5: enable drop with rr_ptr at 2
    do_reset();
    @(negedge clk);
    chk("t4_err_cleared", 64'(o_credit_err), 64'd0);
    step();
    set_req(1, 1'b1, 1, 32'h0000_0101);
    step();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, r, 32'h5500_0000 + 32'(r));
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_ready_off", 64'(req_ready), 64'd0);
      chk("t5_valid", 64'(o_valid), (k == 0) ? 64'd1 : 64'd0);
      chk("t5_en", 64'(o_en), (k == 0) ? 64'd1 : 64'd0);
      step();
    end
    i_en = 1'b1;
    @(negedge clk);
    chk("t5_r2_first", 64'(req_ready), 64'b0100);
    chk("t5_en_lag", 64'(o_en), 64'd0);
    step();
    @(negedge clk);
    chk("t5_en_on", 64'(o_en), 64'd1);
    chk("t5_gid2", 64'(o_grant_id), 64'd2);
    chk("t5_cmd2", 64'(o_cmd), 64'd2);

    // 6: reset while r1 holds the grant
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, r, 32'h6600_0000 + 32'(r));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_suppress", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid0", 64'(o_valid), 64'd0);
    chk("t6_r0_first", 64'(req_ready), 64'b0001);
    chk("t6_model_credit0", 64'(m_credit[0]), 64'd4);
    step();
    @(negedge clk);
    chk("t6_gid0", 64'(o_grant_id), 64'd0);
    chk("t6_valid1", 64'(o_valid), 64'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
